// File: rtl/adma_as_atx_split.sv
// Splits one DMA descriptor into AXI address transactions capped at MAX_BURST beats
// that never cross a 4 KB page. Define ADMA_ATX_OUTSTD_LIMIT_EN to throttle on outstanding ATXs.
module adma_as_atx_split #(
   parameter int ADDR_W       = 32,
   parameter int DMA_LENGTH_W = 16,
   parameter int DATA_W       = 32,
   parameter int MAX_BURST    = 16,
   parameter int MAX_OUTSTD   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tx_vld_i,
   output logic                    tx_rdy_o,
   input  logic [ADDR_W-1:0]       tx_addr_i,
   input  logic [DMA_LENGTH_W-1:0] tx_len_i,
   output logic                    atx_vld_o,
   input  logic                    atx_rdy_i,
   output logic [ADDR_W-1:0]       atx_addr_o,
   output logic [7:0]              atx_len_o,
   output logic                    atx_start,
   output logic                    atx_start_last,
   input  logic                    atx_done
);

   localparam int BPB     = DATA_W / 8;
   localparam int LOG_BPB = $clog2(BPB);
   localparam int REM_W   = DMA_LENGTH_W + 1;
   localparam int CMP_W   = (REM_W > 13) ? REM_W : 13;
   localparam logic [CMP_W-1:0] MAX_BURST_C = CMP_W'(MAX_BURST);

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_ISSUE} state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [CMP_W-1:0]   beats_q, beats_d;
   logic               last_q, last_d;
   logic               tx_rdy_q, tx_rdy_d;
   logic               atx_vld_q, atx_vld_d;
   logic [ADDR_W-1:0]  atx_addr_q, atx_addr_d;
   logic [7:0]         atx_len_q, atx_len_d;

   logic [12:0]        page_room;
   logic [CMP_W-1:0]   bnd_c, rem_ext, beats_c;
   logic               handshake;
   logic               throttle_ok;

   // Valid/ready: a transfer happens on a cycle where both are high; once atx_vld_o
   // rises it is held, with address/len/last stable, until atx_rdy_i accepts it.
   assign handshake = atx_vld_q & atx_rdy_i;

   // Beats left before the next 4 KB page boundary.
   assign page_room = 13'd4096 - {1'b0, cur_addr_q[11:0]};
   assign bnd_c     = CMP_W'(page_room >> LOG_BPB);
   assign rem_ext   = CMP_W'(rem_q);

   always_comb begin
      beats_c = rem_ext;
      if (MAX_BURST_C < beats_c) beats_c = MAX_BURST_C;
      if (bnd_c < beats_c)       beats_c = bnd_c;
   end

`ifdef ADMA_ATX_OUTSTD_LIMIT_EN
   localparam int OUT_W = $clog2(MAX_OUTSTD + 1);
   logic [OUT_W-1:0] outstd_q, outstd_d;

   always_comb begin
      outstd_d = outstd_q;
      if (handshake && !atx_done)
         outstd_d = outstd_q + OUT_W'(1);
      else if (atx_done && !handshake && (outstd_q != '0))
         outstd_d = outstd_q - OUT_W'(1);
   end

   // Using the next count lets a done pulse release a throttled ATX one cycle later.
   assign throttle_ok = (outstd_d < OUT_W'(MAX_OUTSTD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) outstd_q <= '0;
      else        outstd_q <= outstd_d;
   end
`else
   localparam int unused_max_outstd = MAX_OUTSTD;
   logic unused_done;
   assign unused_done = atx_done;
   assign throttle_ok = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      beats_d    = beats_q;
      last_d     = last_q;
      atx_addr_d = atx_addr_q;
      atx_len_d  = atx_len_q;
      case (state_q)
         ST_IDLE: begin
            if (tx_vld_i && tx_rdy_q) begin
               cur_addr_d = tx_addr_i & ~ADDR_W'(BPB - 1);
               rem_d      = REM_W'(tx_len_i) + REM_W'(1);
               state_d    = ST_CALC;
            end
         end
         ST_CALC: begin
            atx_addr_d = cur_addr_q;
            atx_len_d  = beats_c[7:0] - 8'd1;
            beats_d    = beats_c;
            last_d     = (beats_c == rem_ext);
            state_d    = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (handshake) begin
               cur_addr_d = cur_addr_q + (ADDR_W'(beats_q) << LOG_BPB);
               rem_d      = rem_q - REM_W'(beats_q);
               state_d    = last_q ? ST_IDLE : ST_CALC;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      tx_rdy_d  = (state_d == ST_IDLE);
      atx_vld_d = (state_d == ST_ISSUE) && (atx_vld_q || throttle_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= '0;
         rem_q      <= '0;
         beats_q    <= '0;
         last_q     <= 1'b0;
         tx_rdy_q   <= 1'b0;
         atx_vld_q  <= 1'b0;
         atx_addr_q <= '0;
         atx_len_q  <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         beats_q    <= beats_d;
         last_q     <= last_d;
         tx_rdy_q   <= tx_rdy_d;
         atx_vld_q  <= atx_vld_d;
         atx_addr_q <= atx_addr_d;
         atx_len_q  <= atx_len_d;
      end
   end

   assign tx_rdy_o       = tx_rdy_q;
   assign atx_vld_o      = atx_vld_q;
   assign atx_addr_o     = atx_addr_q;
   assign atx_len_o      = atx_len_q;
   assign atx_start      = handshake;
   assign atx_start_last = last_q & atx_vld_q;

endmodule

// File: doc/adma_as_atx_split.md
# adma_as_atx_split

Splits one DMA transfer descriptor (start address plus beat count) into a sequence of AXI-legal address transactions (ATXs). Each ATX is capped at `MAX_BURST` beats and never crosses a 4 KB boundary. The block sits directly upstream of the transaction-status tracker: its `atx_start` / `atx_start_last` outputs drive that tracker's inputs. Its ATX channel drives the AR/AW address generator.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DMA_LENGTH_W`, 16, width of the descriptor beat count.
- `DATA_W`, 32, data-bus width in bits. Bytes per beat `BPB = DATA_W/8`, a power of 2.
- `MAX_BURST`, 16, maximum beats per ATX, 1..256.
- `MAX_OUTSTD`, 2, maximum number of started but not-done ATXs. Used only with the config macro.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `tx_vld_i`  in  1  descriptor valid.
- `tx_rdy_o`  out  1  descriptor ready.
- `tx_addr_i`  in  `ADDR_W`  start byte address. Low `log2(BPB)` bits are ignored and forced to 0.
- `tx_len_i`  in  `DMA_LENGTH_W`  beats minus 1.
- `atx_vld_o`  out  1  ATX valid.
- `atx_rdy_i`  in  1  ATX ready.
- `atx_addr_o`  out  `ADDR_W`  ATX start address.
- `atx_len_o`  out  8  ATX beats minus 1 (AXI LEN).
- `atx_start`  out  1  ATX handshake pulse, equal to `atx_vld_o & atx_rdy_i`.
- `atx_start_last`  out  1  the current ATX is the final ATX of the descriptor; held for the whole time `atx_vld_o` is high.
- `atx_done`  in  1  one-cycle pulse per completed ATX, from downstream.

## Operation
- **FSM states:** IDLE, CALC, ISSUE.
- **IDLE:**
  - `tx_rdy_o=1`.
  - On `tx_vld_i & tx_rdy_o`: latch `cur_addr = tx_addr_i & ~(BPB-1)` and `rem = tx_len_i + 1`, then go to CALC.
  - `rem` is `DMA_LENGTH_W+1` bits wide, so no overflow at `tx_len_i` = all-ones.
- **CALC:**
  - `bnd = (4096 - cur_addr[11:0]) >> log2(BPB)`.
  - `beats = min(rem, MAX_BURST, bnd)`.
  - Register `atx_addr_o = cur_addr`, `atx_len_o = beats-1`, `last = (beats == rem)`, then go to ISSUE.
- **ISSUE:**
  - `atx_vld_o = 1`, gated by the throttle when that is compiled in.
  - `atx_addr_o`, `atx_len_o` and `atx_start_last` stay stable until the handshake.
  - On handshake: `cur_addr += beats*BPB` and `rem -= beats`. If `last`, go to IDLE; otherwise go to CALC.
- `tx_rdy_o` is 0 in CALC and ISSUE; only one descriptor is in flight.
- **Outstanding counter:**
  - `outstd` increments on `atx_start` and decrements on `atx_done`; it is unchanged when both occur in the same cycle.
  - Width is `clog2(MAX_OUTSTD+1)`.
  - An `atx_done` while `outstd == 0` is ignored, with a saturating guard.
- **Address arithmetic:** wraps modulo `2^ADDR_W`, with no error.

## Timing
- **Reset values:** `tx_rdy_o=0` during reset and 1 from the first cycle after reset in IDLE. `atx_vld_o=0`, `atx_start=0`, `atx_start_last=0`, `atx_addr_o=0`, `atx_len_o=0`, `outstd=0`, state=IDLE.
- **Latency:** descriptor handshake at cycle T gives CALC at T+1 and `atx_vld_o=1` at T+2.
- **Throughput:** after an ATX handshake at cycle U, the next ATX is valid at U+2, because one CALC cycle is spent per ATX. After the final ATX handshake at U, `tx_rdy_o=1` at U+1.
- **Handshake rule:** `atx_vld_o`, once high, does not drop until `atx_rdy_i`, except when throttled before assertion. The throttle decision is made on entry to ISSUE and whenever `outstd` changes while `atx_vld_o` is low.
- **Reset mid-operation:** asynchronously returns every register to its reset value. A partially issued descriptor is discarded.

## Configuration
- **`ADMA_ATX_OUTSTD_LIMIT_EN` defined:**
  - `atx_vld_o = (state==ISSUE) & (outstd < MAX_OUTSTD)`.
  - Once asserted, it stays asserted until the handshake.
- **Not defined:**
  - The `outstd` counter is removed and `atx_done` is unused.
  - `atx_vld_o = (state==ISSUE)`.

## Test plan
- **Single burst:** `BPB=4`, `MAX_BURST=16`; descriptor `addr=0x1000`, `len=15` → one ATX `0x1000/LEN 15`, `atx_start_last=1`, `tx_rdy_o=1` one cycle after the handshake.
- **Multi-burst:** `addr=0x0`, `len=39` → ATXs `0x000/15`, `0x040/15`, `0x080/7`; `atx_start_last` is high only on the third; `atx_vld_o` gaps are exactly one cycle with `atx_rdy_i` held at 1.
- **4 KB crossing:** `addr=0x0FF0`, `len=7` → `0x0FF0/LEN 3`, then `0x1000/LEN 3` with last=1; a misaligned `addr=0x0FF3` behaves identically.
- **Backpressure:** hold `atx_rdy_i=0` for 5 cycles during ISSUE → `atx_vld_o`, `atx_addr_o`, `atx_len_o` and `atx_start_last` are stable; `atx_start=0` throughout.
- **Throttle (macro on, `MAX_OUTSTD=2`):** `addr=0x0`, `len=47`, `atx_rdy_i=1`, no `atx_done` → two ATXs issue and the third `atx_vld_o` stays 0. One `atx_done` pulse → third ATX valid the next cycle. A simultaneous `atx_start` and `atx_done` leaves `outstd` unchanged.
- **Reset mid-ISSUE:** assert `rst_n=0` after the second ATX of a 3-ATX descriptor → all outputs return to reset values immediately. After release, a new descriptor `addr=0x2000`, `len=0` → single ATX `0x2000/LEN 0`, last=1.
